// File: rtl/reg_pkg.sv
// Shared register-file constants, reused by reg_group and reg_writeback.
package reg_pkg;

  localparam int NREGS     = 4;
  localparam int REG_IDX_W = 2;
  localparam int DWIDTH    = 16;

  localparam logic [DWIDTH-1:0] REG_DEFAULT = {DWIDTH{1'b0}};

  // One-hot write strobe for a register index.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    reg_onehot = {{(NREGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle between the execute stage (master) and reg_writeback (slave).
//
// Handshake: a write request transfers at a rising clk edge where wb_valid
// and wb_ready are both 1. wb_ready depends only on internal state (never on
// wb_valid), and wb_valid with wb_ready=0 has no effect. stall=1 keeps the
// queue from issuing on that edge. reg_en/d_in/en_out drive reg_group, which
// commits d_in at the edge ending a cycle in which reg_en is non-zero.
interface reg_writeback_if #(
  parameter int DWIDTH = 16
);
  import reg_pkg::NREGS;
  import reg_pkg::REG_IDX_W;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [DWIDTH-1:0]    wb_data;
  logic                 stall;
  logic [NREGS-1:0]     reg_en;
  logic [DWIDTH-1:0]    d_in;
  logic                 en_out;
  logic [NREGS-1:0]     busy;
  logic                 empty;
  logic                 full;

  modport master (
    output wb_valid, wb_rd, wb_data, stall,
    input  wb_ready, reg_en, d_in, en_out, busy, empty, full
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, stall,
    output wb_ready, reg_en, d_in, en_out, busy, empty, full
  );

endinterface

// File: rtl/wb_fifo.sv
// Write-request queue: DEPTH entries of W bits, head visible on dout.
// Callers must not push when full or pop when empty.
module wb_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;

  // Storage is not reset; the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/reg_writeback.sv
// Queues register writes from execute and issues one per cycle to reg_group
// as a registered one-hot strobe, tracking pending writes per register.
module reg_writeback
  import reg_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_writeback_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = REG_IDX_W + DWIDTH;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [FW-1:0]        fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [AW:0]          fifo_count;
  logic [REG_IDX_W-1:0] head_rd;
  logic [DWIDTH-1:0]    head_data;

  logic [NREGS-1:0]     reg_en_q;
  logic [DWIDTH-1:0]    d_in_q;
  logic                 en_out_q;
  logic [CW-1:0]        pend_cnt [NREGS];
  logic [NREGS-1:0]     busy_w;

  // A full queue refuses pushes even when it also pops that cycle.
  assign fifo_push = bus.wb_valid && !fifo_full;
  assign fifo_pop  = !fifo_empty && !bus.stall;

  wb_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({bus.wb_rd, bus.wb_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_rd   = fifo_dout[FW-1:DWIDTH];
  assign head_data = fifo_dout[DWIDTH-1:0];

  // Issue stage: a popped head becomes a single-cycle strobe; d_in holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_en_q <= '0;
      d_in_q   <= '0;
      en_out_q <= 1'b0;
    end else if (fifo_pop) begin
      reg_en_q <= reg_onehot(head_rd);
      d_in_q   <= head_data;
      en_out_q <= 1'b1;
    end else begin
      reg_en_q <= '0;
      en_out_q <= 1'b0;
    end
  end

  // Pending counters: +1 on accept, -1 when the strobe for that register retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) pend_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        case ({fifo_push && (bus.wb_rd == REG_IDX_W'(i)), reg_en_q[i]})
          2'b10:   pend_cnt[i] <= pend_cnt[i] + CW'(1);
          2'b01:   pend_cnt[i] <= pend_cnt[i] - CW'(1);
          default: pend_cnt[i] <= pend_cnt[i];
        endcase
      end
    end
  end

  // Busy is a pure decode of the registered counters.
  always_comb begin
    busy_w = '0;
    for (int i = 0; i < NREGS; i++) busy_w[i] = (pend_cnt[i] != '0);
  end

  assign bus.wb_ready = !fifo_full;
  assign bus.reg_en   = reg_en_q;
  assign bus.d_in     = d_in_q;
  assign bus.en_out   = en_out_q;
  assign bus.busy     = busy_w;
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;

endmodule
